// File: rtl/ysyx_2022040010_dcache_axi_bridge_pkg.sv
// Shared definitions for the data-side single-beat AXI4 bridge.
package ysyx_2022040010_dcache_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_AW,
    ST_WR_B,
    ST_DONE
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_2022040010_dcache_axi_bridge_if.sv
// AXI4 bus bundle between the dcache bridge (master) and memory (slave).
interface ysyx_2022040010_dcache_axi_bridge_if #(
  parameter int AXI_ADDR_W = 32
);
  logic [3:0]            arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [3:0]            rid;
  logic [63:0]           rdata_i;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  logic [3:0]            awid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [63:0]           wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [3:0]            bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata_i, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata_i, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/ysyx_2022040010_dcache_axi_bridge.sv
// Single-outstanding, single-beat AXI4 master for the data-side uncache path.
// Returns read data with a one-cycle refresh pulse that releases the stall.
module ysyx_2022040010_dcache_axi_bridge
  import ysyx_2022040010_dcache_axi_bridge_pkg::*;
#(
  parameter int         AXI_ADDR_W = 32,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_e,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wsel,
  output logic        refresh,
  output logic [63:0] rdata,
  output logic        resp_err,
  output logic        busy,
  ysyx_2022040010_dcache_axi_bridge_if.master axi
);

  state_e                  state_q, state_d;
  logic [AXI_ADDR_W-1:3]   addr_q, addr_d;
  logic [63:0]             wdata_q, wdata_d;
  logic [7:0]              wsel_q, wsel_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [63:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  // Response ID/last and the sub-doubleword address bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{req_addr, axi.rid, axi.bid, axi.rlast};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wsel_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wsel_q    <= wsel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wsel_d    = wsel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_e) begin
          addr_d    = req_addr[AXI_ADDR_W-1:3];
          wdata_d   = req_wdata;
          wsel_d    = req_wsel;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we ? ST_WR_AW : ST_RD_A;
        end
      end
      ST_RD_A: begin
        if (axi.arready) state_d = ST_RD_D;
      end
      ST_RD_D: begin
        if (axi.rvalid) begin
          rdata_d = axi.rdata_i;
          err_d   = (axi.rresp != AXI_RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_WR_AW: begin
        // AW and W retire independently; leave once both have, even in the same cycle.
        aw_done_d = aw_done_q | axi.awready;
        w_done_d  = w_done_q | axi.wready;
        if (aw_done_d && w_done_d) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        if (axi.bvalid) begin
          err_d   = (axi.bresp != AXI_RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign refresh  = (state_q == ST_DONE);
  assign resp_err = (state_q == ST_DONE) && err_q;
  assign busy     = (state_q != ST_IDLE);
  assign rdata    = rdata_q;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = {addr_q, 3'b000};
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = AXI_SIZE_8B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = (state_q == ST_RD_A);
  assign axi.rready  = (state_q == ST_RD_D);

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = {addr_q, 3'b000};
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = AXI_SIZE_8B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = (state_q == ST_WR_AW) && !aw_done_q;

  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wsel_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (state_q == ST_WR_AW) && !w_done_q;

  assign axi.bready  = (state_q == ST_WR_B);

endmodule

// File: doc/ysyx_2022040010_dcache_axi_bridge.md
# ysyx_2022040010_dcache_axi_bridge

Single-outstanding AXI4 master that sits directly downstream of the data-side uncache/tag controller. It latches one memory request (read or masked write), runs it as a single-beat AXI4 transaction, and returns the read data with a one-cycle `refresh` pulse that releases the controller's stall. No bursts, no reordering, and only one transaction in flight.

## Interface
Parameters:
- `AXI_ADDR_W`, default 32: AXI address width; `req_addr[AXI_ADDR_W-1:0]` is used.
- `AXI_ID`, default 4'd1: constant value driven on `arid`/`awid`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_e`  in  1  request valid; sampled only in IDLE
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  64  byte address
- `req_wdata`  in  64  write data, lane-aligned
- `req_wsel`  in  8  write byte strobes
- `refresh`  out  1  one-cycle completion pulse
- `rdata`  out  64  read data; valid from `refresh` until the next completion
- `resp_err`  out  1  high with `refresh` if xRESP != OKAY
- `busy`  out  1  high in every state except IDLE
- AR channel: `arid` out 4, `araddr` out AXI_ADDR_W, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1
- R channel: `rid` in 4, `rdata_i` in 64, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1
- AW channel: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid` (out), `awready` (in); same widths as AR
- W channel: `wdata` out 64, `wstrb` out 8, `wlast` out 1, `wvalid` out 1, `wready` in 1
- B channel: `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1

## Operation
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE with `req_e`=1: latch we/addr/wdata/wsel. Go to RD_A if `req_we`=0, otherwise WR_AW.
- RD_A: `arvalid`=1 with `araddr` = latched addr with bits [2:0] cleared. On `arready`, go to RD_D.
- RD_D: `rready`=1. On `rvalid`, capture `rdata_i` into `rdata`, set err = (`rresp`!=0), and go to DONE.
- WR_AW: `awvalid` and `wvalid` rise together. Each drops independently on its own handshake, tracked by flags `aw_done` and `w_done`. When both are done (including in the same cycle), go to WR_B.
- WR_B: `bready`=1. On `bvalid`, set err = (`bresp`!=0) and go to DONE.
- DONE: `refresh`=1 and `resp_err`=err for exactly one cycle, then IDLE. `req_e` is not sampled in DONE.
- Constant fields: `arlen`/`awlen`=0, `arsize`/`awsize`=3'b011, `arburst`/`awburst`=INCR, `wlast`=1, `wstrb`=latched wsel.
- A write with `wsel`=0 is still issued on the bus.
- `req_e` is ignored while `busy`.
- `rid`, `bid` and `rlast` are not checked.

## Timing
- Reset values: all valid/ready outputs 0, `refresh` 0, `resp_err` 0, `rdata` 0, `busy` 0, state IDLE, `aw_done`/`w_done` 0. Address, data and strobe outputs are 0.
- Reset mid-transaction drops all valids on the next edge and abandons the transaction. The bench must not rely on completion.
- Read latency: `req_e` at cycle 0 gives `arvalid` at cycle 1. With zero-wait slaves, `rvalid` arrives at cycle 2 and `refresh` at cycle 3.
- Write latency: with zero wait, AW and W complete at cycle 1, `bvalid` arrives at cycle 2, and `refresh` at cycle 3.
- Valids hold, with stable payload, until their handshake. They never drop early.
- `refresh` pulses are always at least 2 cycles apart.

## Structure
- Shared defines package holds:
  - state encodings;
  - `AXI_BURST_INCR` = 2'b01;
  - `AXI_SIZE_8B` = 3'b011;
  - `AXI_RESP_OKAY` = 2'b00.
- No sub-module. The block is one FSM plus a latched request register.

## Test plan
- Read, zero-wait slave, addr 0x8000_0013 returning 0x1122334455667788 -> `araddr`=0x8000_0010, `rdata`=0x1122334455667788, `refresh` at cycle 3, `resp_err`=0.
- Write, addr 0x8000_0008, data 0xAABB, wsel 8'h03; slave delays `awready` 3 cycles and asserts `wready` immediately -> `wvalid` drops after cycle 1, `awvalid` held until cycle 4, one `refresh` after `bvalid`.
- Read with `rresp`=2'b10 -> `refresh` pulse with `resp_err`=1; `resp_err`=0 the following cycle.
- `req_e` held high for 10 cycles, read, 2-cycle slave -> transactions back-to-back, each restarting from IDLE after DONE, no overlap; exactly one `refresh` per transaction.
- `rst` asserted in RD_D with `rvalid` pending -> next cycle `rready`=0, `busy`=0, no `refresh`; a new request afterwards completes normally.
